// File: rtl/cnn_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer_if
// Engine-side and ROM-side bus of the CNN layer sequencer.
//   rom_addr / rom_data           : parameter ROM read port (1-cycle latency)
//   data / addr / we              : write port into the convolution engine
//   img_input, conv_weight1..3    : mode strobes qualifying the write port
//   srt_layer1..3 / done_layer1..3: per-layer run request / completion
// master = sequencer, slave = engine plus ROM.
// -----------------------------------------------------------------------------
interface cnn_layer_sequencer_if;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [15:0] data;
   logic [15:0] addr;
   logic        we;
   logic        img_input;
   logic        conv_weight1;
   logic        conv_weight2;
   logic        conv_weight3;
   logic        srt_layer1;
   logic        srt_layer2;
   logic        srt_layer3;
   logic        done_layer1;
   logic        done_layer2;
   logic        done_layer3;

   modport master (
      output rom_addr, data, addr, we,
      output img_input, conv_weight1, conv_weight2, conv_weight3,
      output srt_layer1, srt_layer2, srt_layer3,
      input  rom_data, done_layer1, done_layer2, done_layer3
   );

   modport slave (
      input  rom_addr, data, addr, we,
      input  img_input, conv_weight1, conv_weight2, conv_weight3,
      input  srt_layer1, srt_layer2, srt_layer3,
      output rom_data, done_layer1, done_layer2, done_layer3
   );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
// Streams the image and three weight banks from the parameter ROM into the
// convolution engine, then runs layers 1..3 in order.
//   clk, reset_n : clock, asynchronous active-low reset
//   start, abort : host request / synchronous abort back to IDLE
//   eng          : ROM read port + engine write port, strobes and layer handshake
//   busy, done   : sequence in progress / one-cycle completion pulse
//   timeout_err  : sticky RUN-phase timeout flag, cleared by an accepted start
//   phase        : current state code
// -----------------------------------------------------------------------------
module cnn_layer_sequencer #(
   parameter int unsigned IMG_SIZE = 18,
   parameter int unsigned IMG_BASE = 0,
   parameter int unsigned W1_BASE  = 324,
   parameter int unsigned W2_BASE  = 378,
   parameter int unsigned W3_BASE  = 522,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         abort,
   cnn_layer_sequencer_if.master        eng,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout_err,
   output logic [3:0]                   phase
);

   typedef enum logic [3:0] {
      IDLE = 4'd0, LOAD_IMG = 4'd1, LOAD_W1 = 4'd2, RUN1 = 4'd3, LOAD_W2 = 4'd4,
      RUN2 = 4'd5, LOAD_W3 = 4'd6, RUN3 = 4'd7, DONE = 4'd8, ERR = 4'd9
   } state_t;

   localparam logic [15:0] IMG_LEN = 16'(IMG_SIZE * IMG_SIZE);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   function automatic logic [15:0] sec_base(state_t s);
      case (s)
         LOAD_IMG: sec_base = 16'(IMG_BASE);
         LOAD_W1:  sec_base = 16'(W1_BASE);
         LOAD_W2:  sec_base = 16'(W2_BASE);
         LOAD_W3:  sec_base = 16'(W3_BASE);
         default:  sec_base = 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] sec_len(state_t s);
      case (s)
         LOAD_IMG: sec_len = IMG_LEN;
         LOAD_W1:  sec_len = 16'd54;
         LOAD_W2:  sec_len = 16'd144;
         LOAD_W3:  sec_len = 16'd288;
         default:  sec_len = 16'd0;
      endcase
   endfunction

   // {conv_weight3, conv_weight2, conv_weight1, img_input}
   function automatic logic [3:0] mode_of(state_t s);
      case (s)
         LOAD_IMG: mode_of = 4'b0001;
         LOAD_W1:  mode_of = 4'b0010;
         LOAD_W2:  mode_of = 4'b0100;
         LOAD_W3:  mode_of = 4'b1000;
         default:  mode_of = 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] srt_of(state_t s);
      case (s)
         RUN1:    srt_of = 3'b001;
         RUN2:    srt_of = 3'b010;
         RUN3:    srt_of = 3'b100;
         default: srt_of = 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] layer_of(state_t s);
      case (s)
         RUN2:    layer_of = 2'd1;
         RUN3:    layer_of = 2'd2;
         default: layer_of = 2'd0;
      endcase
   endfunction

   function automatic state_t next_of(state_t s);
      case (s)
         IDLE:     next_of = LOAD_IMG;
         LOAD_IMG: next_of = LOAD_W1;
         LOAD_W1:  next_of = RUN1;
         RUN1:     next_of = LOAD_W2;
         LOAD_W2:  next_of = RUN2;
         RUN2:     next_of = LOAD_W3;
         LOAD_W3:  next_of = RUN3;
         RUN3:     next_of = DONE;
         default:  next_of = IDLE;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;        // cycles since LOAD entry; doubles as ROM index k
   logic [15:0] tcnt_q, tcnt_d;      // cycles since RUN entry
   logic [3:0]  k9_q, k9_d;          // weight-section engine address (k mod 9)
   logic [15:0] rom_addr_q, rom_addr_d;
   logic [15:0] data_q, data_d;
   logic [15:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  mode_q, mode_d;
   logic [2:0]  srt_q, srt_d;
   logic        fin_q, fin_d;        // layer done accepted; spend the gap cycle
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        timeout_err_q, timeout_err_d;

   logic [2:0]  done_in;
   logic [15:0] len;
   logic [15:0] base;
   logic        enter;

   assign done_in = {eng.done_layer3, eng.done_layer2, eng.done_layer1};
   assign len     = sec_len(state_q);
   assign base    = sec_base(state_q);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; that is what keeps this block free of inferred latches.
      state_d       = state_q;
      cnt_d         = cnt_q;
      tcnt_d        = tcnt_q;
      k9_d          = k9_q;
      rom_addr_d    = rom_addr_q;
      data_d        = data_q;
      addr_d        = addr_q;
      we_d          = 1'b0;
      mode_d        = mode_q;
      srt_d         = srt_q;
      fin_d         = fin_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      enter         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               enter         = 1'b1;
               timeout_err_d = 1'b0;
            end
         end
         LOAD_IMG, LOAD_W1, LOAD_W2, LOAD_W3: begin
            // Cycle c issues ROM word c (c < len) and writes word c-1, which
            // arrived this cycle (1 <= c <= len). The strobe covers one cycle
            // past the last write, then one all-low cycle separates phases.
            cnt_d = cnt_q + 16'd1;
            if (cnt_q + 16'd1 < len) begin
               rom_addr_d = base + cnt_q + 16'd1;
            end
            if (cnt_q != 16'd0 && cnt_q <= len) begin
               we_d   = 1'b1;
               data_d = eng.rom_data;
               addr_d = (state_q == LOAD_IMG) ? cnt_q - 16'd1 : {12'd0, k9_q};
               k9_d   = (k9_q == 4'd8) ? 4'd0 : k9_q + 4'd1;
            end
            if (cnt_q == len + 16'd2) begin
               mode_d = 4'b0000;
            end
            if (cnt_q == len + 16'd3) begin
               enter = 1'b1;
            end
         end
         RUN1, RUN2, RUN3: begin
            tcnt_d = tcnt_q + 16'd1;
            if (fin_q) begin
               enter = 1'b1;
            end else if (tcnt_q == TO_LAST) begin
               state_d       = ERR;
               srt_d         = 3'b000;
               timeout_err_d = 1'b1;
            end else if (tcnt_q != 16'd0 && done_in[layer_of(state_q)]) begin
               // srt has been high for two cycles here, so a done level left
               // over from before this layer started is not mistaken for ours.
               srt_d = 3'b000;
               fin_d = 1'b1;
            end
         end
         DONE, ERR: enter = 1'b1;
         default:   state_d = IDLE;
      endcase

      if (enter) begin
         state_d = next_of(state_q);
         cnt_d   = 16'd0;
         tcnt_d  = 16'd0;
         k9_d    = 4'd0;
         fin_d   = 1'b0;
         mode_d  = mode_of(state_d);
         srt_d   = srt_of(state_d);
         if (mode_of(state_d) != 4'b0000) begin
            rom_addr_d = sec_base(state_d);
         end
         done_d  = (state_d == DONE);
      end

      if (abort) begin
         state_d    = IDLE;
         rom_addr_d = rom_addr_q;
         we_d       = 1'b0;
         mode_d     = 4'b0000;
         srt_d      = 3'b000;
         fin_d      = 1'b0;
         done_d     = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tcnt_q        <= '0;
         k9_q          <= '0;
         rom_addr_q    <= '0;
         data_q        <= '0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         mode_q        <= '0;
         srt_q         <= '0;
         fin_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tcnt_q        <= tcnt_d;
         k9_q          <= k9_d;
         rom_addr_q    <= rom_addr_d;
         data_q        <= data_d;
         addr_q        <= addr_d;
         we_q          <= we_d;
         mode_q        <= mode_d;
         srt_q         <= srt_d;
         fin_q         <= fin_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign eng.rom_addr     = rom_addr_q;
   assign eng.data         = data_q;
   assign eng.addr         = addr_q;
   assign eng.we           = we_q;
   assign eng.img_input    = mode_q[0];
   assign eng.conv_weight1 = mode_q[1];
   assign eng.conv_weight2 = mode_q[2];
   assign eng.conv_weight3 = mode_q[3];
   assign eng.srt_layer1   = srt_q[0];
   assign eng.srt_layer2   = srt_q[1];
   assign eng.srt_layer3   = srt_q[2];
   assign busy             = busy_q;
   assign done             = done_q;
   assign timeout_err      = timeout_err_q;
   assign phase            = state_q;

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
Top-level controller for the three-layer convolution engine. It streams the input image and the three weight banks from a shared parameter ROM into the engine over the engine's data/addr/we port, driving the matching mode strobes. It then runs layers 1-3 in order, holding each start strobe until that layer reports done. Sits between the host (start/abort/status) and the convolution top, and owns the ROM read port.

Parameters:
IMG_SIZE, 18, input image edge; image section = IMG_SIZE*IMG_SIZE words
IMG_BASE, 0, ROM word address of image pixel 0 (row-major)
W1_BASE, 324, ROM address of layer-1 weights (6 kernels x 9 = 54 words)
W2_BASE, 378, ROM address of layer-2 weights (16 x 9 = 144 words)
W3_BASE, 522, ROM address of layer-3 weights (32 x 9 = 288 words)
TIMEOUT, 65535, max cycles allowed in any RUN phase

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a full inference
abort  in  1  synchronous abort; returns to IDLE
rom_addr  out  16  parameter ROM read address (1-cycle read latency)
rom_data  in  16  ROM read data, valid the cycle after rom_addr
data  out  16  write data to engine
addr  out  16  write address to engine
we  out  1  write enable to engine
img_input  out  1  engine port carries image data
conv_weight1 / conv_weight2 / conv_weight3  out  1 each  engine port carries layer-N weights
srt_layer1 / srt_layer2 / srt_layer3  out  1 each  run layer N (level)
done_layer1 / done_layer2 / done_layer3  in  1 each  layer N complete
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful completion
timeout_err  out  1  sticky; set on RUN timeout, cleared by next accepted start
phase  out  4  current state encoding

Behaviour:
- Reset: all outputs 0, phase=IDLE, all counters 0.
- States and phase codes: IDLE=0, LOAD_IMG=1, LOAD_W1=2, RUN1=3, LOAD_W2=4, RUN2=5, LOAD_W3=6, RUN3=7, DONE=8, ERR=9.
- Transitions: IDLE -start-> LOAD_IMG -> LOAD_W1 -> RUN1 -> LOAD_W2 -> RUN2 -> LOAD_W3 -> RUN3 -> DONE -> IDLE (one cycle in DONE). Any RUN phase goes to ERR on timeout; ERR -> IDLE after one cycle.
- start is ignored while busy. busy=1 in every state except IDLE.
- LOAD sections:
  - Section length N: image = IMG_SIZE^2; W1 = 54; W2 = 144; W3 = 288.
  - Index k counts 0..N-1. rom_addr = base+k, issued at cycle t.
  - At the edge after t+1: data = rom_data, we = 1, and the engine address is registered.
  - Engine address: addr = k for the image section; addr = k mod 9 for weight sections.
  - we is high for exactly N consecutive cycles per section, 2 cycles after the first rom_addr.
- Mode strobes: img_input (LOAD_IMG) or conv_weightN (LOAD_WN) goes high on state entry. It stays high until one cycle after the final we, then drops. All mode strobes are one-hot or zero.
- Idle gap: at least one cycle with all strobes and we low between consecutive phases.
- RUN phases:
  - srt_layerN = 1 from state entry until the cycle after an accepted done_layerN, then 0.
  - done_layerN is accepted only once srt_layerN has been high for at least 2 cycles; this masks stale levels.
  - done inputs for other layers are ignored.
- Timeout: a counter clears on RUN entry and increments each RUN cycle. Reaching TIMEOUT goes to ERR: srt dropped, timeout_err=1.
- abort (any state): next edge forces phase=IDLE and we, all strobes, and busy to 0. done and timeout_err are unaffected. abort has priority over start and done_layer in the same cycle.
- rom_addr holds its last value outside LOAD states.
- Counter widths: k is 16 bits (covers IMG_SIZE up to 255); the timeout counter is 16 bits.

Test Plan:
- Full run, IMG_SIZE=18, ROM[i]=i, each done_layerN returned 20 cycles after srt rises:
  - 324 image writes, data=addr=0..323.
  - 54 writes under conv_weight1 with data 324..377, addr cycling 0..8.
  - 144 W2 writes and 288 W3 writes, totalling 810 we cycles.
  - srt1, srt2, srt3 pulses in order; done pulses once; phase returns to 0.
- Stale done: done_layer1 tied high before RUN1 -> srt_layer1 still high for at least 2 cycles before the RUN1 exit; no early skip.
- Timeout with TIMEOUT=100, done_layer2 never asserted -> exactly 100 cycles in RUN2, then phase=9, timeout_err=1, srt_layer2=0. A subsequent start clears timeout_err.
- Abort during LOAD_W2 at k=50 -> we=0, conv_weight2=0, phase=0 next cycle. A restart rewrites from image pixel 0.
- start pulsed while in RUN1 -> ignored, no restart; start and abort in the same cycle in IDLE -> stays IDLE.
- Reset asserted mid-RUN3 -> all outputs 0 immediately (asynchronous); after release, phase=0 and busy=0.
